// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the four-way memory access arbiter.
package mem_arb_pkg;

    localparam int N_REQ      = 4;
    localparam int IDX_W      = 2;
    localparam int DATA_WORDS = 4;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // One executer's request, normalised into a single bundle so the granted
    // request can be latched with one assignment.
    typedef struct packed {
        logic                          stack;
        logic                          write;
        logic                          byte_op;
        logic [2:0]                    size;
        logic [15:0]                   stack_addr;
        logic [31:0]                   gen_addr;
        logic [DATA_WORDS-1:0][15:0]   data;
    } mem_req_t;

    // One-hot decode of a requester index.
    function automatic logic [N_REQ-1:0] onehot4(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mem_access_arbiter_pick.sv
// Round-robin priority pick over four requesters: first active index at or
// after rr_ptr, wrapping modulo 4.
module rr_priority_pick4
    import mem_arb_pkg::*;
(
    input  logic [N_REQ-1:0] active,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    // active vector rotated so that bit 0 is the requester at rr_ptr
    logic [N_REQ-1:0] rotated;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rotate
            assign rotated[gi] = active[IDX_W'(rr_ptr + IDX_W'(gi))];
        end
    endgenerate

    // Lowest rotated offset wins; scan from the top so the last hit is the lowest.
    logic [IDX_W-1:0] offset;
    always_comb begin
        valid  = 1'b0;
        offset = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                valid  = 1'b1;
                offset = IDX_W'(k);
            end
        end
    end

    assign index = IDX_W'(rr_ptr + offset);

endmodule

// File: rtl/mem_access_arbiter.sv
// Four-executer arbiter in front of a single-port memory system. Grants one
// stack or general request at a time round-robin, holds it on the mem_* port
// until acknowledged and steers the ack pulses back to the granted executer.
module mem_access_arbiter
    import mem_arb_pkg::*;
(
    input  logic                                     main_clk,
    input  logic                                     main_reset,
    input  logic [N_REQ-1:0]                         req_stack_requesting,
    input  logic [N_REQ-1:0]                         req_stack_write,
    input  logic [N_REQ-1:0][2:0]                    req_stack_size,
    input  logic [N_REQ-1:0][15:0]                   req_stack_address,
    input  logic [N_REQ-1:0]                         req_general_requesting,
    input  logic [N_REQ-1:0]                         req_general_write,
    input  logic [N_REQ-1:0]                         req_general_byte,
    input  logic [N_REQ-1:0][31:0]                   req_general_address,
    input  logic [N_REQ-1:0][DATA_WORDS-1:0][15:0]   req_data_in,
    output logic [N_REQ-1:0]                         req_ack_pulse,
    output logic [N_REQ-1:0]                         req_will_ack_pulse,
    output logic                                     mem_stack_requesting,
    output logic                                     mem_stack_write,
    output logic [2:0]                               mem_stack_size,
    output logic [15:0]                              mem_stack_address,
    output logic                                     mem_general_requesting,
    output logic                                     mem_general_write,
    output logic                                     mem_general_byte,
    output logic [31:0]                              mem_general_address,
    output logic [DATA_WORDS-1:0][15:0]              mem_data_in,
    input  logic                                     mem_ack_pulse,
    input  logic                                     mem_will_ack_pulse,
    output logic [IDX_W-1:0]                         grant_index,
    output logic                                     busy
);

    arb_state_t       state_reg, state_next;
    logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [IDX_W-1:0] grant_reg, grant_next;
    logic [N_REQ-1:0] ack_mask_reg, ack_mask_next;
    mem_req_t         mem_req_reg, mem_req_next;
    logic             stack_req_reg, stack_req_next;
    logic             gen_req_reg, gen_req_next;

    mem_req_t         req_bundle [N_REQ];
    logic [N_REQ-1:0] active;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_index;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            // Stack wins when both are raised; general fields are then ignored.
            assign req_bundle[gi].stack      = req_stack_requesting[gi];
            assign req_bundle[gi].write      = req_stack_requesting[gi] ? req_stack_write[gi]
                                                                        : req_general_write[gi];
            assign req_bundle[gi].byte_op    = ~req_stack_requesting[gi] & req_general_byte[gi];
            assign req_bundle[gi].size       = req_stack_size[gi];
            assign req_bundle[gi].stack_addr = req_stack_address[gi];
            assign req_bundle[gi].gen_addr   = req_general_address[gi];
            assign req_bundle[gi].data       = req_data_in[gi];

            // The one-cycle mask hides a request that is still high on the
            // cycle right after its own ack.
            assign active[gi] = (req_stack_requesting[gi] | req_general_requesting[gi])
                                & ~ack_mask_reg[gi];

            // Ack pulses are routed combinationally, only while a grant is live.
            assign req_ack_pulse[gi]      = (state_reg == ARB_BUSY)
                                            && (grant_reg == IDX_W'(gi)) && mem_ack_pulse;
            assign req_will_ack_pulse[gi] = (state_reg == ARB_BUSY)
                                            && (grant_reg == IDX_W'(gi)) && mem_will_ack_pulse;
        end
    endgenerate

    rr_priority_pick4 u_pick (
        .active (active),
        .rr_ptr (rr_ptr_reg),
        .valid  (pick_valid),
        .index  (pick_index)
    );

    // Next-state logic: latch a grant from IDLE, release it on the downstream ack.
    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        grant_next     = grant_reg;
        ack_mask_next  = '0;
        mem_req_next   = mem_req_reg;
        stack_req_next = stack_req_reg;
        gen_req_next   = gen_req_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (pick_valid) begin
                    grant_next     = pick_index;
                    mem_req_next   = req_bundle[pick_index];
                    stack_req_next = req_bundle[pick_index].stack;
                    gen_req_next   = ~req_bundle[pick_index].stack;
                    state_next     = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (mem_ack_pulse) begin
                    stack_req_next = 1'b0;
                    gen_req_next   = 1'b0;
                    rr_ptr_next    = IDX_W'(grant_reg + 1'b1);
                    ack_mask_next  = onehot4(grant_reg);
                    state_next     = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // State register; reset abandons any outstanding transaction.
    always_ff @(posedge main_clk or posedge main_reset) begin
        if (main_reset) begin
            state_reg <= ARB_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Grant bookkeeping and the held downstream request.
    always_ff @(posedge main_clk or posedge main_reset) begin
        if (main_reset) begin
            rr_ptr_reg    <= '0;
            grant_reg     <= '0;
            ack_mask_reg  <= '0;
            mem_req_reg   <= '0;
            stack_req_reg <= 1'b0;
            gen_req_reg   <= 1'b0;
        end else begin
            rr_ptr_reg    <= rr_ptr_next;
            grant_reg     <= grant_next;
            ack_mask_reg  <= ack_mask_next;
            mem_req_reg   <= mem_req_next;
            stack_req_reg <= stack_req_next;
            gen_req_reg   <= gen_req_next;
        end
    end

    assign mem_stack_requesting   = stack_req_reg;
    assign mem_stack_write        = mem_req_reg.stack & mem_req_reg.write;
    assign mem_stack_size         = mem_req_reg.size;
    assign mem_stack_address      = mem_req_reg.stack_addr;
    assign mem_general_requesting = gen_req_reg;
    assign mem_general_write      = ~mem_req_reg.stack & mem_req_reg.write;
    assign mem_general_byte       = mem_req_reg.byte_op;
    assign mem_general_address    = mem_req_reg.gen_addr;
    assign mem_data_in            = mem_req_reg.data;
    assign grant_index            = grant_reg;
    assign busy                   = (state_reg == ARB_BUSY);

    // An executer must not raise stack and general together.
    a_single_type: assert property (@(posedge main_clk) disable iff (main_reset)
        (req_stack_requesting & req_general_requesting) == '0);

    // The memory system must not acknowledge when nothing is outstanding.
    a_no_idle_ack: assert property (@(posedge main_clk) disable iff (main_reset)
        (state_reg == ARB_IDLE) |-> !(mem_ack_pulse || mem_will_ack_pulse));

    // Acks only ever reach one executer.
    a_ack_onehot: assert property (@(posedge main_clk) disable iff (main_reset)
        $onehot0(req_ack_pulse));

endmodule
